// File: rtl/fll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fll_seq_pkg
// Purpose  : Shared constants for the FLL frequency sequencer: FSM state
//            encoding, FLL register address, CONFIG1 field positions and
//            error codes, plus a helper that builds the CONFIG1 write word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fll_seq_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_REQ    = 3'd1;
  localparam logic [2:0] S_RD_REL    = 3'd2;
  localparam logic [2:0] S_WR_REQ    = 3'd3;
  localparam logic [2:0] S_WR_REL    = 3'd4;
  localparam logic [2:0] S_LOCK_WAIT = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  // FLL register map
  localparam logic [1:0] FLL_ADDR_CONFIG1 = 2'b01;

  // CONFIG1 fields touched by the sequencer
  localparam int MULT_LSB = 0;
  localparam int MULT_W   = 16;
  localparam int DIV_LSB  = 26;
  localparam int DIV_W    = 4;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ACK_TMO  = 2'd1;
  localparam logic [1:0] ERR_LOCK_TMO = 2'd2;

  // Replace the MULT and DIV fields of a CONFIG1 word, keep everything else.
  function automatic logic [31:0] merge_config1(input logic [31:0]       shadow,
                                                input logic [MULT_W-1:0] mult,
                                                input logic [DIV_W-1:0]  div);
    logic [31:0] word;
    word = shadow;
    word[MULT_LSB +: MULT_W] = mult;
    word[DIV_LSB  +: DIV_W]  = div;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fll_freq_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fll_cmd_if / fll_cfg_if
// Purpose  : Bundles for the two sides of the FLL frequency sequencer.
//            fll_cmd_if : command/status port (master = clock manager,
//                         slave = sequencer).
//            fll_cfg_if : FLL req/ack configuration port (master = sequencer,
//                         slave = FLL).
// Ports    : none (signal bundles with modports)
// Revision : 1.0 - initial release
// ============================================================================
interface fll_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_mult;
  logic [3:0]  cmd_div;
  logic        cmd_nowait;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output cmd_valid, cmd_mult, cmd_div, cmd_nowait,
    input  cmd_ready, busy, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_mult, cmd_div, cmd_nowait,
    output cmd_ready, busy, done, err, err_code
  );
endinterface

interface fll_cfg_if;
  logic        fll_req;
  logic        fll_wrn;
  logic [1:0]  fll_add;
  logic [31:0] fll_data;
  logic        fll_ack;
  logic [31:0] fll_r_data;
  logic        fll_lock;

  modport master (
    output fll_req, fll_wrn, fll_add, fll_data,
    input  fll_ack, fll_r_data, fll_lock
  );

  modport slave (
    input  fll_req, fll_wrn, fll_add, fll_data,
    output fll_ack, fll_r_data, fll_lock
  );
endinterface
`default_nettype wire

// File: rtl/fll_sync2.sv
`default_nettype none
// ============================================================================
// Module   : fll_sync2
// Purpose  : Two-flop synchroniser for one asynchronous level signal.
// Ports    : clk_i  - destination clock
//            rst_i  - synchronous active-high reset (clears both stages)
//            d_i    - asynchronous input
//            q_o    - synchronised output (two clk_i cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module fll_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/fll_freq_seq.sv
`default_nettype none
// ============================================================================
// Module   : fll_freq_seq
// Purpose  : Retunes one FLL without CPU involvement. A command (mult, div,
//            nowait) triggers a read-modify-write of FLL CONFIG1 over the
//            four-phase req/ack port, followed by an optional wait for a
//            stable lock. Completion is signalled by a done or err pulse.
// Ports    : HCLK, HRESET - clock, synchronous active-high reset
//            cmd (fll_cmd_if.slave)  - cmd_valid/ready/mult/div/nowait in,
//                                      busy/done/err/err_code out
//            fll (fll_cfg_if.master) - fll_req/wrn/add/data out,
//                                      fll_ack/r_data/lock in (async)
// Revision : 1.0 - initial release
// ============================================================================
module fll_freq_seq
  import fll_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 256,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 16,
  parameter int CNT_W        = 13
) (
  input  logic      HCLK,
  input  logic      HRESET,
  fll_cmd_if.slave  cmd,
  fll_cfg_if.master fll
);

  localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] STB_LIM  = CNT_W'(LOCK_STABLE);

  // --------------------------------------------------------------------------
  // Synchronisers: the FSM never looks at the raw FLL-domain signals
  // --------------------------------------------------------------------------
  logic ack_s;
  logic lock_s;

  fll_sync2 u_sync_ack (
    .clk_i (HCLK),
    .rst_i (HRESET),
    .d_i   (fll.fll_ack),
    .q_o   (ack_s)
  );

  fll_sync2 u_sync_lock (
    .clk_i (HCLK),
    .rst_i (HRESET),
    .d_i   (fll.fll_lock),
    .q_o   (lock_s)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,    state_d;
  logic               req_q,      req_d;
  logic               wrn_q,      wrn_d;
  logic [1:0]         add_q,      add_d;
  logic [31:0]        data_q,     data_d;
  logic [31:0]        shadow_q,   shadow_d;
  logic [15:0]        mult_q,     mult_d;
  logic [3:0]         div_q,      div_d;
  logic               nowait_q,   nowait_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   tmo_q,      tmo_d;
  logic [CNT_W-1:0]   stb_q,      stb_d;

  logic               ready;
  logic               accept;
  logic [CNT_W-1:0]   tmo_inc;
  logic [CNT_W-1:0]   stb_inc;
  logic               ack_expired;

  // A stale ack left over from an aborted handshake must drain before the
  // next command can start a new one.
  assign ready       = (state_q == S_IDLE) && !ack_s;
  assign accept      = cmd.cmd_valid && ready;
  assign tmo_inc     = tmo_q + CNT_W'(1);
  assign stb_inc     = stb_q + CNT_W'(1);
  assign ack_expired = (tmo_inc == ACK_LIM);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wrn_d      = wrn_q;
    add_d      = add_q;
    data_d     = data_q;
    shadow_d   = shadow_q;
    mult_d     = mult_q;
    div_d      = div_q;
    nowait_d   = nowait_q;
    err_code_d = err_code_q;
    tmo_d      = tmo_inc;
    stb_d      = stb_q;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        stb_d = '0;
        if (accept) begin
          mult_d     = cmd.cmd_mult;
          div_d      = cmd.cmd_div;
          nowait_d   = cmd.cmd_nowait;
          err_code_d = ERR_NONE;
          req_d      = 1'b1;
          wrn_d      = 1'b1;
          add_d      = FLL_ADDR_CONFIG1;
          state_d    = S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        if (ack_s) begin
          shadow_d = fll.fll_r_data;
          req_d    = 1'b0;
          state_d  = S_RD_REL;
        end else if (ack_expired) begin
          req_d      = 1'b0;
          err_code_d = ERR_ACK_TMO;
          state_d    = S_ERR;
        end
      end

      S_RD_REL: begin
        if (!ack_s) begin
          req_d   = 1'b1;
          wrn_d   = 1'b0;
          add_d   = FLL_ADDR_CONFIG1;
          data_d  = merge_config1(shadow_q, mult_q, div_q);
          state_d = S_WR_REQ;
        end else if (ack_expired) begin
          err_code_d = ERR_ACK_TMO;
          state_d    = S_ERR;
        end
      end

      S_WR_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_WR_REL;
        end else if (ack_expired) begin
          req_d      = 1'b0;
          err_code_d = ERR_ACK_TMO;
          state_d    = S_ERR;
        end
      end

      S_WR_REL: begin
        if (!ack_s) begin
          state_d = nowait_q ? S_DONE : S_LOCK_WAIT;
        end else if (ack_expired) begin
          err_code_d = ERR_ACK_TMO;
          state_d    = S_ERR;
        end
      end

      S_LOCK_WAIT: begin
        stb_d = lock_s ? stb_inc : '0;
        // Stable lock is checked first so it wins a same-cycle timeout.
        if (lock_s && (stb_inc == STB_LIM)) begin
          state_d = S_DONE;
        end else if (tmo_inc == LOCK_LIM) begin
          err_code_d = ERR_LOCK_TMO;
          state_d    = S_ERR;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Both counters restart on every state entry.
    if (state_d != state_q) begin
      tmo_d = '0;
      stb_d = '0;
    end
  end

  // Pulses are registered so they line up exactly with the DONE/ERR state.
  assign done_d = (state_d == S_DONE);
  assign err_d  = (state_d == S_ERR);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      wrn_q      <= 1'b1;
      add_q      <= 2'b00;
      data_q     <= 32'h0;
      shadow_q   <= 32'h0;
      mult_q     <= 16'h0;
      div_q      <= 4'h0;
      nowait_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      tmo_q      <= '0;
      stb_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wrn_q      <= wrn_d;
      add_q      <= add_d;
      data_q     <= data_d;
      shadow_q   <= shadow_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      nowait_q   <= nowait_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
      stb_q      <= stb_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd.cmd_ready = ready;
  assign cmd.busy      = (state_q != S_IDLE);
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.err_code  = err_code_q;

  assign fll.fll_req   = req_q;
  assign fll.fll_wrn   = wrn_q;
  assign fll.fll_add   = add_q;
  assign fll.fll_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_fll_freq_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fll_freq_seq
// Purpose  : Self-checking bench for fll_freq_seq. A behavioural FLL slave
//            answers the req/ack port with a programmable delay and holds a
//            CONFIG1 register; expected write words and latencies are derived
//            from the command fields and from the documented state timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fll_freq_seq;

  localparam int ACK_TIMEOUT  = 256;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int LOCK_STABLE  = 16;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  fll_cmd_if u_cmd ();
  fll_cfg_if u_fll ();

  fll_freq_seq u_dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .cmd    (u_cmd),
    .fll    (u_fll)
  );

  // Command-side drive
  logic        tb_valid  = 1'b0;
  logic [15:0] tb_mult   = 16'h0;
  logic [3:0]  tb_div    = 4'h0;
  logic        tb_nowait = 1'b0;
  assign u_cmd.cmd_valid  = tb_valid;
  assign u_cmd.cmd_mult   = tb_mult;
  assign u_cmd.cmd_div    = tb_div;
  assign u_cmd.cmd_nowait = tb_nowait;

  wire        ready_w    = u_cmd.cmd_ready;
  wire        busy_w     = u_cmd.busy;
  wire        done_w     = u_cmd.done;
  wire        err_w      = u_cmd.err;
  wire [1:0]  err_code_w = u_cmd.err_code;
  wire        req_w      = u_fll.fll_req;
  wire        wrn_w      = u_fll.fll_wrn;
  wire [1:0]  add_w      = u_fll.fll_add;
  wire [31:0] data_w     = u_fll.fll_data;

  // --------------------------------------------------------------------------
  // Behavioural FLL slave
  // --------------------------------------------------------------------------
  int          m_delay   = 3;      // cycles from seeing req to raising ack
  logic        m_noack   = 1'b0;   // never answer
  logic        stale_ack = 1'b0;   // bench-forced late ack
  logic [1:0]  lock_mode = 2'd1;   // 0 stuck low, 1 high, 2 10-high/1-low
  logic        preset_en = 1'b0;
  logic [31:0] preset_val = 32'h0;

  logic        m_ack     = 1'b0;
  logic [31:0] m_rdata   = 32'h0;
  logic [31:0] m_cfg1    = 32'h0;
  logic [31:0] m_last_w  = 32'h0;
  int          m_cnt     = 0;
  int          m_rd      = 0;
  int          m_wr      = 0;
  int          m_bad_add = 0;
  int          tog       = 0;

  always @(posedge HCLK) begin
    if (preset_en) m_cfg1 <= preset_val;
    if (!req_w) begin
      m_cnt <= 0;
      m_ack <= 1'b0;
    end else if (!m_ack && !m_noack) begin
      if (m_cnt >= m_delay - 1) begin
        m_ack <= 1'b1;
        if (add_w != 2'b01) m_bad_add <= m_bad_add + 1;
        if (wrn_w) begin
          m_rdata <= m_cfg1;
          m_rd    <= m_rd + 1;
        end else begin
          m_cfg1   <= data_w;
          m_last_w <= data_w;
          m_wr     <= m_wr + 1;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge HCLK) tog <= (tog == 10) ? 0 : tog + 1;

  assign u_fll.fll_ack    = m_ack | stale_ack;
  assign u_fll.fll_r_data = m_rdata;
  assign u_fll.fll_lock   = (lock_mode == 2'd1) ? 1'b1 :
                            (lock_mode == 2'd2) ? (tog < 10) : 1'b0;

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // CONFIG1 after retune: bits 31:30 and 25:16 survive, DIV and MULT replaced.
  function automatic logic [31:0] exp_cfg(input logic [31:0] old, input logic [15:0] m,
                                          input logic [3:0] d);
    return {old[31:30], d, old[25:16], m};
  endfunction

  task automatic preset(input logic [31:0] v);
    @(negedge HCLK);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge HCLK);
    preset_en  = 1'b0;
  endtask

  // Present a command, wait (bounded) for acceptance, then release valid.
  task automatic send_cmd(input logic [15:0] m, input logic [3:0] d, input logic nw,
                          output bit ok);
    @(negedge HCLK);
    tb_valid = 1'b1; tb_mult = m; tb_div = d; tb_nowait = nw;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ready_w) begin ok = 1'b1; break; end
      @(negedge HCLK);
    end
    @(posedge HCLK);
    @(negedge HCLK);
    tb_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  // Wait (bounded) for done or err; also report the level one cycle later.
  task automatic wait_end(input int budget, output bit got_done, output bit got_err,
                          output int lat, output logic after_pulse);
    got_done = 1'b0; got_err = 1'b0; lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge HCLK);
      if (done_w || err_w) begin
        got_done = done_w; got_err = err_w; lat = cyc - acc_cyc;
        break;
      end
    end
    @(negedge HCLK);
    after_pulse = done_w | err_w;
  endtask

  // --------------------------------------------------------------------------
  // Directed + randomized sequence
  // --------------------------------------------------------------------------
  initial begin : main
    bit          ok, gd, ge;
    logic        after;
    int          lat_wait, lat_nw, lat_nw_l0, lat_lto, lat_tog, lat_x;
    int          rd0, wr0, reqc;
    logic [31:0] pv, ev;
    logic [15:0] rm;
    logic [3:0]  rdv;
    logic        rnw;

    // ---- reset state
    repeat (4) @(negedge HCLK);
    chk("rst_req", {31'h0, req_w}, 32'h0);
    chk("rst_wrn", {31'h0, wrn_w}, 32'h1);
    chk("rst_add", {30'h0, add_w}, 32'h0);
    chk("rst_data", data_w, 32'h0);
    chk("rst_done_err", {30'h0, done_w, err_w}, 32'h0);
    chk("rst_code", {30'h0, err_code_w}, 32'h0);
    chk("rst_busy", {31'h0, busy_w}, 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("idle_ready", {31'h0, ready_w}, 32'h1);

    // ---- 1: full RMW with lock wait
    m_delay = 3; lock_mode = 2'd1;
    preset(32'hC40005F5);
    rd0 = m_rd; wr0 = m_wr;
    send_cmd(16'h0100, 4'h2, 1'b0, ok);
    chk("t1_accept", {31'h0, ok}, 32'h1);
    chk("t1_busy", {31'h0, busy_w}, 32'h1);
    chk("t1_ready_busy", {31'h0, ready_w}, 32'h0);
    wait_end(400, gd, ge, lat_wait, after);
    chk("t1_done", {30'h0, gd, ge}, 32'h2);
    chk("t1_pulse_width", {31'h0, after}, 32'h0);
    chk("t1_reads", 32'(m_rd - rd0), 32'd1);
    chk("t1_writes", 32'(m_wr - wr0), 32'd1);
    chk("t1_wdata", m_last_w, 32'hC8000100);
    chk("t1_code", {30'h0, err_code_w}, 32'h0);

    // ---- 2: nowait, same FLL timing; lock wait disappears
    preset(32'hC40005F5);
    send_cmd(16'h0100, 4'h2, 1'b1, ok);
    wait_end(400, gd, ge, lat_nw, after);
    chk("t2_done", {30'h0, gd, ge}, 32'h2);
    chk("t2_wdata", m_last_w, 32'hC8000100);
    chk("t2_lockwait_len", 32'(lat_wait - lat_nw), 32'(LOCK_STABLE));
    lock_mode = 2'd0;
    send_cmd(16'h0100, 4'h2, 1'b1, ok);
    wait_end(400, gd, ge, lat_nw_l0, after);
    chk("t2_nolock_done", {30'h0, gd, ge}, 32'h2);
    chk("t2_nolock_lat", 32'(lat_nw_l0), 32'(lat_nw));

    // ---- 3: read never acked, then a late ack lingers
    m_noack = 1'b1;
    send_cmd(16'h1234, 4'h5, 1'b1, ok);
    reqc = 1;  // the cycle sampled inside send_cmd already had req high
    gd = 1'b0; ge = 1'b0;
    for (int i = 0; i < ACK_TIMEOUT + 40; i++) begin
      @(negedge HCLK);
      if (err_w) begin ge = 1'b1; break; end
      if (req_w) reqc++;
    end
    chk("t3_err", {31'h0, ge}, 32'h1);
    chk("t3_req_cycles", 32'(reqc), 32'(ACK_TIMEOUT));
    chk("t3_req_dropped", {31'h0, req_w}, 32'h0);
    chk("t3_code", {30'h0, err_code_w}, 32'h1);
    m_noack = 1'b0;
    @(negedge HCLK);
    stale_ack = 1'b1;
    repeat (4) @(negedge HCLK);
    chk("t3_stale_ready", {31'h0, ready_w}, 32'h0);
    tb_valid = 1'b1; tb_mult = 16'hBEEF; tb_div = 4'h9; tb_nowait = 1'b1;
    repeat (5) @(negedge HCLK);
    chk("t3_stale_busy", {31'h0, busy_w | ready_w}, 32'h0);
    chk("t3_code_held", {30'h0, err_code_w}, 32'h1);
    stale_ack = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (ready_w) begin ok = 1'b1; break; end
    end
    chk("t3_ready_back", {31'h0, ok}, 32'h1);
    pv = m_cfg1;
    @(posedge HCLK);
    @(negedge HCLK);
    tb_valid = 1'b0; acc_cyc = cyc;
    chk("t3_code_cleared", {30'h0, err_code_w}, 32'h0);
    wait_end(400, gd, ge, lat_x, after);
    chk("t3_recover", {30'h0, gd, ge}, 32'h2);
    chk("t3_recover_wdata", m_last_w, exp_cfg(pv, 16'hBEEF, 4'h9));

    // ---- 4: lock stuck low, then lock chattering
    lock_mode = 2'd0;
    send_cmd(16'h0200, 4'h3, 1'b0, ok);
    wait_end(LOCK_TIMEOUT + 400, gd, ge, lat_lto, after);
    chk("t4_err", {30'h0, gd, ge}, 32'h1);
    chk("t4_code", {30'h0, err_code_w}, 32'h2);
    chk("t4_lock_tmo_len", 32'(lat_lto - lat_nw), 32'(LOCK_TIMEOUT));
    lock_mode = 2'd2;
    send_cmd(16'h0300, 4'h4, 1'b0, ok);
    wait_end(LOCK_TIMEOUT + 400, gd, ge, lat_tog, after);
    chk("t4_tog_err", {30'h0, gd, ge}, 32'h1);
    chk("t4_tog_code", {30'h0, err_code_w}, 32'h2);
    chk("t4_tog_len", 32'(lat_tog - lat_nw), 32'(LOCK_TIMEOUT));

    // ---- 5: cmd_valid held through a busy period with changing fields
    lock_mode = 2'd1;
    preset(32'h5A5A_A5A5);
    rd0 = m_rd;
    @(negedge HCLK);
    tb_valid = 1'b1; tb_mult = 16'h1111; tb_div = 4'hA; tb_nowait = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    tb_mult = 16'h2222; tb_div = 4'h6; tb_nowait = 1'b0;
    ok = 1'b0; gd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_w) gd = 1'b1;
      if (ready_w) begin ok = 1'b1; break; end
      @(negedge HCLK);
    end
    chk("t5_second_ready", {31'h0, ok}, 32'h1);
    chk("t5_first_done_before", {31'h0, gd}, 32'h1);
    chk("t5_one_read_first", 32'(m_rd - rd0), 32'd1);
    chk("t5_first_wdata", m_last_w, exp_cfg(32'h5A5A_A5A5, 16'h1111, 4'hA));
    @(posedge HCLK);
    @(negedge HCLK);
    tb_valid = 1'b0; acc_cyc = cyc;
    wait_end(400, gd, ge, lat_x, after);
    chk("t5_second_done", {30'h0, gd, ge}, 32'h2);
    chk("t5_second_wdata", m_last_w,
        exp_cfg(exp_cfg(32'h5A5A_A5A5, 16'h1111, 4'hA), 16'h2222, 4'h6));

    // ---- 6: reset while the write request is outstanding
    preset(32'h0F0F_0F0F);
    send_cmd(16'h7777, 4'h1, 1'b1, ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (req_w && !wrn_w) begin ok = 1'b1; break; end
      @(negedge HCLK);
    end
    chk("t6_saw_wr_req", {31'h0, ok}, 32'h1);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    chk("t6_req", {31'h0, req_w}, 32'h0);
    chk("t6_wrn_add", {29'h0, wrn_w, add_w}, 32'h4);
    chk("t6_data", data_w, 32'h0);
    chk("t6_flags", {27'h0, busy_w, done_w, err_w, err_code_w}, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (5) @(negedge HCLK);
    pv = m_cfg1;
    send_cmd(16'h4321, 4'hF, 1'b0, ok);
    chk("t6_fresh_accept", {31'h0, ok}, 32'h1);
    wait_end(400, gd, ge, lat_x, after);
    chk("t6_fresh_done", {30'h0, gd, ge}, 32'h2);
    chk("t6_fresh_wdata", m_last_w, exp_cfg(pv, 16'h4321, 4'hF));

    // ---- randomized retunes
    for (int k = 0; k < 8; k++) begin
      pv  = $urandom;
      rm  = 16'($urandom);
      rdv = 4'($urandom);
      rnw = 1'($urandom);
      m_delay = int'($urandom_range(1, 5));
      preset(pv);
      rd0 = m_rd; wr0 = m_wr;
      send_cmd(rm, rdv, rnw, ok);
      wait_end(400, gd, ge, lat_x, after);
      ev = exp_cfg(pv, rm, rdv);
      chk($sformatf("rnd%0d_done", k), {30'h0, gd, ge}, 32'h2);
      chk($sformatf("rnd%0d_wdata", k), m_last_w, ev);
      chk($sformatf("rnd%0d_ops", k), 32'((m_rd - rd0) * 16 + (m_wr - wr0)), 32'h11);
      chk($sformatf("rnd%0d_code", k), {30'h0, err_code_w}, 32'h0);
    end

    chk("fll_addr_always_config1", 32'(m_bad_add), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation did not finish: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
